gpu_spi_frontend_n: RTL and testbench
=====================================

// Module: gpu_spi_frontend_n
// PURPOSE
//  SPI slave front end for the GPU, generalised to NUM_POLYS polygons with parametrised field widths.
//  Receives LSB-first command frames and holds polygon, background and screen state for the rasteriser.
//  Polygon/bg writes land in shadow registers; they commit to the active outputs on frame_sync, or at once when the screen is off.
//  Adds MISO status readback and a sticky command-error flag.
// PARAMETERS
//  NUM_POLYS   4      polygon slots, 1..16
//  X_W         7      vertex x width
//  Y_W         6      vertex y width
//  COLOR_W     6      colour width, polygon and bg
//  DEPTH_W     3      depth width
//  SYNC_STAGES 2      input synchroniser depth, >=2
//  DEVICE_ID   8'hB6  returned by status read
//  localparams: PAY_W=COLOR_W+3*X_W+3*Y_W+DEPTH_W (48 at defaults); FRAME_BITS=8+PAY_W (56 at defaults)
// PORTS
//  clk              in   1                    system clock
//  rst_n            in   1                    synchronous, active-low reset
//  sck_in           in   1                    SPI clock, async
//  cs_in            in   1                    SPI chip select, active low, async
//  mosi_in          in   1                    SPI data in, async
//  miso_out         out  1                    SPI data out
//  miso_oe          out  1                    MISO drive enable
//  en_load          in   1                    SPI accept window (hsync region)
//  frame_sync       in   1                    1-cycle pulse at frame start; commits shadow to active
//  bg_color_out     out  COLOR_W              active background colour
//  poly_color_out   out  NUM_POLYS*COLOR_W    packed; slot i at [i*COLOR_W +: COLOR_W]
//  v{0,1,2}_x_out   out  NUM_POLYS*X_W        packed per slot, same rule
//  v{0,1,2}_y_out   out  NUM_POLYS*Y_W        packed per slot
//  poly_depth_out   out  NUM_POLYS*DEPTH_W    packed per slot
//  poly_enable_out  out  NUM_POLYS            active per-slot enable
//  en_screen_out    out  1                    screen enable
//  cmd_error_out    out  1                    sticky error flag
// BEHAVIOUR
//  Reset: every output, shadow register, counter and synchroniser = 0. miso_out=0, miso_oe=0.
//  Reset mid-frame aborts the frame with no state change.
//  sck, cs and mosi each pass through SYNC_STAGES flops. rise = sync sck 0->1; fall = 1->0.
//  Accept: a rise is accepted only if cs_s==0, (en_load | ~en_screen_out), and bit_cnt<FRAME_BITS.
//    On accept: shift mosi_s into frame bit[bit_cnt], then bit_cnt++. Frame is LSB-first: first bit = cmd bit0.
//  bit_cnt saturates at FRAME_BITS; further rises are ignored until cs_s goes high.
//  cs_s high: bit_cnt=0, frame buffer cleared, miso_oe=0. A partial frame is discarded; no state change.
//  Decode fires as a 1-cycle pulse in the cycle after bit_cnt reaches FRAME_BITS. cmd = frame[7:0].
//  Payload is LSB-first from frame bit 8: color, v0x, v1x, v2x, v0y, v1y, v2y, depth.
//  Commands:
//    8'h8i  WRITE_POLY i: shadow[i] = payload; shadow_en[i] = 1
//    8'h4i  CLEAR_POLY i: shadow[i] = 0; shadow_en[i] = 0
//    8'h01  SET_BG: shadow_bg = payload color
//    8'h21 / 8'h20  en_screen_out = 1 / 0, immediate
//    8'h02  STATUS read
//  Errors: i >= NUM_POLYS, or any other opcode -> no register change; cmd_error_out = 1.
//  Commit: on frame_sync, or every cycle while en_screen_out==0, active = shadow (polys, enables, bg).
//    If a decode and a commit fall in the same cycle, the commit copies the pre-write shadow.
//    That write then reaches active at the next commit.
//  STATUS read:
//    After 8 accepted bits with cmd==8'h02, miso_oe=1 for the rest of the frame.
//    Status word S = {cmd_error, en_screen, poly_enable_out, DEVICE_ID}, zero-extended to PAY_W.
//    S is latched when the 8th bit is accepted.
//    miso_out presents S[0] combinationally once oe rises, then advances one bit on each sck fall while oe=1.
//    On the decode pulse of a STATUS frame, cmd_error is cleared. A new error in the same cycle wins (stays 1).
//  cs_in low with the screen on and en_load=0: rises are dropped, not queued.
// TESTING
//  1 Screen off; WRITE_POLY 0x81, payload color=6'h2A v0=(5,3) v1=(100,60) v2=(127,0) depth=5
//      -> slot1 active fields match within 2 cycles of the frame end; poly_enable_out=4'b0010.
//  2 Send 8'h21, then WRITE_POLY 0x80 with sck in en_load windows
//      -> outputs unchanged until frame_sync; updated the cycle after frame_sync.
//  3 Send cmd 8'h84 (NUM_POLYS=4), then 8'h55 -> no register change; cmd_error_out=1.
//      Then STATUS -> MISO returns DEVICE_ID 8'hB6 LSB-first, then error bit=1; error=0 after the frame.
//  4 Raise cs after 30 bits of a WRITE_POLY -> no change.
//      Next full CLEAR_POLY frame -> slot cleared, enable bit 0.
//  5 Drive 60 sck rises in one frame -> only 56 captured; decode once.
//      Assert rst_n=0 mid-frame -> all outputs 0; next frame decodes normally.

Source files
------------

// File: rtl/gpu_spi_frontend_n.sv
// SPI slave front end for the GPU rasteriser.
// Receives LSB-first command frames (8-bit command + packed polygon payload),
// keeps shadow polygon/background registers that commit to the active outputs
// on frame_sync (or continuously while the screen is off), and returns a
// status word on MISO for STATUS commands.
module gpu_spi_frontend_n #(
  parameter int          NUM_POLYS   = 4,
  parameter int          X_W         = 7,
  parameter int          Y_W         = 6,
  parameter int          COLOR_W     = 6,
  parameter int          DEPTH_W     = 3,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  DEVICE_ID   = 8'hB6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sck_in,
  input  logic                         cs_in,
  input  logic                         mosi_in,
  output logic                         miso_out,
  output logic                         miso_oe,
  input  logic                         en_load,
  input  logic                         frame_sync,
  output logic [COLOR_W-1:0]           bg_color_out,
  output logic [NUM_POLYS*COLOR_W-1:0] poly_color_out,
  output logic [NUM_POLYS*X_W-1:0]     v0_x_out,
  output logic [NUM_POLYS*X_W-1:0]     v1_x_out,
  output logic [NUM_POLYS*X_W-1:0]     v2_x_out,
  output logic [NUM_POLYS*Y_W-1:0]     v0_y_out,
  output logic [NUM_POLYS*Y_W-1:0]     v1_y_out,
  output logic [NUM_POLYS*Y_W-1:0]     v2_y_out,
  output logic [NUM_POLYS*DEPTH_W-1:0] poly_depth_out,
  output logic [NUM_POLYS-1:0]         poly_enable_out,
  output logic                         en_screen_out,
  output logic                         cmd_error_out
);

  localparam int PAY_W      = COLOR_W + 3*X_W + 3*Y_W + DEPTH_W;
  localparam int FRAME_BITS = 8 + PAY_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int STAT_W     = 10 + NUM_POLYS;

  // Payload field offsets, in arrival order
  localparam int OFF_C   = 0;
  localparam int OFF_V0X = OFF_C   + COLOR_W;
  localparam int OFF_V1X = OFF_V0X + X_W;
  localparam int OFF_V2X = OFF_V1X + X_W;
  localparam int OFF_V0Y = OFF_V2X + X_W;
  localparam int OFF_V1Y = OFF_V0Y + Y_W;
  localparam int OFF_V2Y = OFF_V1Y + Y_W;
  localparam int OFF_D   = OFF_V2Y + Y_W;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_s, cs_s, mosi_s, sck_d;
  logic                   rise, fall, accept;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_BITS-1:0]  frame;
  logic                   decode;
  logic [7:0]             cmd_at_8th;
  logic [PAY_W-1:0]       status_sh;
  logic                   oe_r;

  logic [PAY_W-1:0]       shadow [NUM_POLYS];
  logic [PAY_W-1:0]       active [NUM_POLYS];
  logic [NUM_POLYS-1:0]   shadow_en, active_en;
  logic [COLOR_W-1:0]     shadow_bg, active_bg;
  logic                   en_screen, cmd_error;

  logic [7:0]             cmd;
  logic [PAY_W-1:0]       payload;
  logic                   idx_ok;
  logic                   dec_wr, dec_clr, dec_bg, dec_on, dec_off, dec_status, dec_err;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_d;
  assign fall   = ~sck_s & sck_d;
  assign accept = rise & ~cs_s & (en_load | ~en_screen) & (bit_cnt < CNT_W'(FRAME_BITS));
  // The 8th bit has not landed in the frame yet when it is accepted
  assign cmd_at_8th = {mosi_s, frame[6:0]};

  assign cmd     = frame[7:0];
  assign payload = frame[FRAME_BITS-1:8];
  assign idx_ok  = ({28'd0, cmd[3:0]} < 32'(NUM_POLYS));

  // Bring the asynchronous SPI pins into the clk domain and keep sck history for edges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      sck_d     <= sck_s;
    end
  end

  // Frame capture, decode pulse generation and MISO status shifter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      frame     <= '0;
      decode    <= 1'b0;
      status_sh <= '0;
      oe_r      <= 1'b0;
    end else if (cs_s) begin
      bit_cnt   <= '0;
      frame     <= '0;
      decode    <= 1'b0;
      oe_r      <= 1'b0;
    end else begin
      decode <= accept && (bit_cnt == CNT_W'(FRAME_BITS - 1));
      if (accept) begin
        frame[bit_cnt] <= mosi_s;
        bit_cnt        <= bit_cnt + CNT_W'(1);
        if ((bit_cnt == CNT_W'(7)) && (cmd_at_8th == 8'h02)) begin
          oe_r      <= 1'b1;
          status_sh <= {{(PAY_W-STAT_W){1'b0}}, cmd_error, en_screen, active_en, DEVICE_ID};
        end
      end else if (fall && oe_r) begin
        status_sh <= {1'b0, status_sh[PAY_W-1:1]};
      end
    end
  end

  // Classify the completed frame into one register action or an error
  always_comb begin
    dec_wr     = 1'b0;
    dec_clr    = 1'b0;
    dec_bg     = 1'b0;
    dec_on     = 1'b0;
    dec_off    = 1'b0;
    dec_status = 1'b0;
    dec_err    = 1'b0;
    if (decode) begin
      case (cmd[7:4])
        4'h8: begin
          if (idx_ok) dec_wr = 1'b1;
          else        dec_err = 1'b1;
        end
        4'h4: begin
          if (idx_ok) dec_clr = 1'b1;
          else        dec_err = 1'b1;
        end
        4'h0: begin
          case (cmd[3:0])
            4'h1:    dec_bg = 1'b1;
            4'h2:    dec_status = 1'b1;
            default: dec_err = 1'b1;
          endcase
        end
        4'h2: begin
          case (cmd[3:0])
            4'h1:    dec_on = 1'b1;
            4'h0:    dec_off = 1'b1;
            default: dec_err = 1'b1;
          endcase
        end
        default: dec_err = 1'b1;
      endcase
    end else begin
      dec_err = 1'b0;
    end
  end

  // Shadow writes, shadow-to-active commit, screen enable and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_POLYS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      shadow_en <= '0;
      active_en <= '0;
      shadow_bg <= '0;
      active_bg <= '0;
      en_screen <= 1'b0;
      cmd_error <= 1'b0;
    end else begin
      // Commit reads the shadow before this cycle's write lands
      if (frame_sync || !en_screen) begin
        for (int i = 0; i < NUM_POLYS; i++) begin
          active[i] <= shadow[i];
        end
        active_en <= shadow_en;
        active_bg <= shadow_bg;
      end
      for (int i = 0; i < NUM_POLYS; i++) begin
        if (dec_wr && (cmd[3:0] == 4'(i))) begin
          shadow[i]    <= payload;
          shadow_en[i] <= 1'b1;
        end else if (dec_clr && (cmd[3:0] == 4'(i))) begin
          shadow[i]    <= '0;
          shadow_en[i] <= 1'b0;
        end
      end
      if (dec_bg) shadow_bg <= payload[OFF_C +: COLOR_W];
      if (dec_on)       en_screen <= 1'b1;
      else if (dec_off) en_screen <= 1'b0;
      if (dec_err)         cmd_error <= 1'b1;
      else if (dec_status) cmd_error <= 1'b0;
    end
  end

  // Unpack the active slots onto the packed output buses
  for (genvar g = 0; g < NUM_POLYS; g++) begin : g_slot
    assign poly_color_out[g*COLOR_W +: COLOR_W] = active[g][OFF_C   +: COLOR_W];
    assign v0_x_out[g*X_W +: X_W]               = active[g][OFF_V0X +: X_W];
    assign v1_x_out[g*X_W +: X_W]               = active[g][OFF_V1X +: X_W];
    assign v2_x_out[g*X_W +: X_W]               = active[g][OFF_V2X +: X_W];
    assign v0_y_out[g*Y_W +: Y_W]               = active[g][OFF_V0Y +: Y_W];
    assign v1_y_out[g*Y_W +: Y_W]               = active[g][OFF_V1Y +: Y_W];
    assign v2_y_out[g*Y_W +: Y_W]               = active[g][OFF_V2Y +: Y_W];
    assign poly_depth_out[g*DEPTH_W +: DEPTH_W] = active[g][OFF_D   +: DEPTH_W];
  end

  assign poly_enable_out = active_en;
  assign bg_color_out    = active_bg;
  assign en_screen_out   = en_screen;
  assign cmd_error_out   = cmd_error;
  assign miso_oe         = oe_r;
  assign miso_out        = oe_r & status_sh[0];

endmodule

// File: tb/tb_gpu_spi_frontend_n.sv
// Scoreboard bench for gpu_spi_frontend_n: the stimulus pushes expected
// output values into a queue, and a monitor on the falling clock edge pops
// and compares them against the DUT.
module tb_gpu_spi_frontend_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck_in = 1'b0, cs_in = 1'b1, mosi_in = 1'b0;
  logic        en_load = 1'b0, frame_sync = 1'b0;
  logic        miso_out, miso_oe;
  logic [5:0]  bg_color_out;
  logic [23:0] poly_color_out;
  logic [27:0] v0_x_out, v1_x_out, v2_x_out;
  logic [23:0] v0_y_out, v1_y_out, v2_y_out;
  logic [11:0] poly_depth_out;
  logic [3:0]  poly_enable_out;
  logic        en_screen_out, cmd_error_out;

  gpu_spi_frontend_n dut (
    .clk(clk), .rst_n(rst_n), .sck_in(sck_in), .cs_in(cs_in), .mosi_in(mosi_in),
    .miso_out(miso_out), .miso_oe(miso_oe), .en_load(en_load), .frame_sync(frame_sync),
    .bg_color_out(bg_color_out), .poly_color_out(poly_color_out),
    .v0_x_out(v0_x_out), .v1_x_out(v1_x_out), .v2_x_out(v2_x_out),
    .v0_y_out(v0_y_out), .v1_y_out(v1_y_out), .v2_y_out(v2_y_out),
    .poly_depth_out(poly_depth_out), .poly_enable_out(poly_enable_out),
    .en_screen_out(en_screen_out), .cmd_error_out(cmd_error_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } item_t;

  item_t q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Reference model of the active state: field order color,v0x,v1x,v2x,v0y,v1y,v2y,depth
  int       mf[4][8];
  int       mbg;
  logic [3:0] men;
  logic     mscr, merr;

  function automatic int fw(input int f);
    case (f)
      0: return 6;
      1, 2, 3: return 7;
      4, 5, 6: return 6;
      default: return 3;
    endcase
  endfunction

  function automatic logic [63:0] dut_val(input int sel);
    case (sel)
      0:  return 64'(bg_color_out);
      1:  return 64'(poly_color_out);
      2:  return 64'(v0_x_out);
      3:  return 64'(v1_x_out);
      4:  return 64'(v2_x_out);
      5:  return 64'(v0_y_out);
      6:  return 64'(v1_y_out);
      7:  return 64'(v2_y_out);
      8:  return 64'(poly_depth_out);
      9:  return 64'(poly_enable_out);
      10: return 64'(en_screen_out);
      11: return 64'(cmd_error_out);
      12: return 64'(miso_out);
      default: return 64'(miso_oe);
    endcase
  endfunction

  function automatic logic [63:0] mk_frame(input int cmd, input int c, input int ax, input int bx,
                                           input int cx, input int ay, input int by, input int cy,
                                           input int d);
    logic [63:0] f;
    f = 64'(cmd & 8'hFF);
    f |= 64'(c)  << 8;
    f |= 64'(ax) << 14;
    f |= 64'(bx) << 21;
    f |= 64'(cx) << 28;
    f |= 64'(ay) << 35;
    f |= 64'(by) << 41;
    f |= 64'(cy) << 47;
    f |= 64'(d)  << 53;
    return f;
  endfunction

  task automatic push(input string name, input int sel, input logic [63:0] exp);
    item_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    q.push_back(it);
  endtask

  task automatic set_slot(input int i, input int c, input int ax, input int bx, input int cx,
                          input int ay, input int by, input int cy, input int d);
    mf[i][0] = c;  mf[i][1] = ax; mf[i][2] = bx; mf[i][3] = cx;
    mf[i][4] = ay; mf[i][5] = by; mf[i][6] = cy; mf[i][7] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 0, 0, 0, 0, 0, 0, 0, 0);
    mbg = 0; men = 4'b0000; mscr = 1'b0; merr = 1'b0;
  endtask

  task automatic expect_all(input string tag);
    string nm[8] = '{"color", "v0x", "v1x", "v2x", "v0y", "v1y", "v2y", "depth"};
    logic [63:0] e;
    push({tag, ".bg"}, 0, 64'(mbg));
    for (int f = 0; f < 8; f++) begin
      e = 64'd0;
      for (int i = 0; i < 4; i++) e |= 64'(mf[i][f]) << (i * fw(f));
      push({tag, ".", nm[f]}, f + 1, e);
    end
    push({tag, ".enable"}, 9, 64'(men));
    push({tag, ".screen"}, 10, 64'(mscr));
    push({tag, ".error"}, 11, 64'(merr));
  endtask

  // Drives n SPI bits LSB-first; optionally checks the status word on MISO
  task automatic send_frame(input logic [63:0] bits, input int n, input bit stat,
                            input logic [63:0] s, input bit raise_cs);
    @(posedge clk); #1 cs_in = 1'b0;
    repeat (4) @(posedge clk);
    for (int k = 0; k < n; k++) begin
      #1 mosi_in = bits[k];
      repeat (4) @(posedge clk);
      #1 sck_in = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      if (stat && k >= 7) begin
        push($sformatf("miso.bit%0d", k - 7), 12, 64'(s[k-7]));
        if (k == 7) push("miso_oe.rise", 13, 64'd1);
      end
      @(posedge clk); #1 sck_in = 1'b0;
    end
    repeat (4) @(posedge clk);
    if (raise_cs) begin
      #1 cs_in = 1'b1;
      repeat (6) @(posedge clk);
    end
    #1;
  endtask

  task automatic pulse_sync();
    @(posedge clk); #1 frame_sync = 1'b1;
    @(posedge clk); #1 frame_sync = 1'b0;
  endtask

  // Monitor: compare every queued expectation against the DUT on the falling edge
  initial begin
    item_t it;
    logic [63:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        it  = q.pop_front();
        got = dut_val(it.sel);
        n_checks++;
        if (got !== it.exp) begin
          n_errors++;
          $display("FAIL %s: got %0h expected %0h", it.name, got, it.exp);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] s;
    model_reset();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    expect_all("reset");
    push("reset.miso", 12, 64'd0);
    push("reset.miso_oe", 13, 64'd0);

    // 1: screen off, writes reach the active outputs right away
    send_frame(mk_frame(8'h81, 6'h2A, 5, 100, 127, 3, 60, 0, 5), 56, 1'b0, 64'd0, 1'b1);
    set_slot(1, 6'h2A, 5, 100, 127, 3, 60, 0, 5);
    men = 4'b0010;
    expect_all("t1.write1");
    send_frame(mk_frame(8'h01, 6'h33, 0, 0, 0, 0, 0, 0, 0), 56, 1'b0, 64'd0, 1'b1);
    mbg = 6'h33;
    expect_all("t1.bg");

    // 2: screen on, writes held in shadow until frame_sync
    send_frame(mk_frame(8'h21, 0, 0, 0, 0, 0, 0, 0, 0), 56, 1'b0, 64'd0, 1'b1);
    mscr = 1'b1;
    expect_all("t2.screen_on");
    en_load = 1'b1;
    send_frame(mk_frame(8'h80, 6'h11, 1, 2, 3, 4, 5, 6, 7), 56, 1'b0, 64'd0, 1'b1);
    en_load = 1'b0;
    repeat (3) @(posedge clk); #1;
    expect_all("t2.held");
    pulse_sync();
    set_slot(0, 6'h11, 1, 2, 3, 4, 5, 6, 7);
    men = 4'b0011;
    expect_all("t2.synced");
    // en_load low with the screen on: rises are dropped
    send_frame(mk_frame(8'h82, 6'h3F, 9, 9, 9, 9, 9, 9, 1), 56, 1'b0, 64'd0, 1'b1);
    pulse_sync();
    expect_all("t2.dropped");

    // 3: errors and status readback
    en_load = 1'b1;
    send_frame(mk_frame(8'h20, 0, 0, 0, 0, 0, 0, 0, 0), 56, 1'b0, 64'd0, 1'b1);
    en_load = 1'b0;
    mscr = 1'b0;
    expect_all("t3.screen_off");
    send_frame(mk_frame(8'h84, 6'h3F, 1, 1, 1, 1, 1, 1, 1), 56, 1'b0, 64'd0, 1'b1);
    merr = 1'b1;
    expect_all("t3.bad_slot");
    send_frame(mk_frame(8'h55, 6'h01, 2, 2, 2, 2, 2, 2, 2), 56, 1'b0, 64'd0, 1'b1);
    expect_all("t3.bad_op");
    s = 64'h0000_0000_0000_00B6 | (64'(men) << 8) | (64'(mscr) << 12) | (64'(merr) << 13);
    send_frame(mk_frame(8'h02, 0, 0, 0, 0, 0, 0, 0, 0), 56, 1'b1, s, 1'b1);
    merr = 1'b0;
    expect_all("t3.status_done");
    push("t3.miso_oe_low", 13, 64'd0);

    // 4: aborted frame, then clear
    send_frame(mk_frame(8'h81, 6'h07, 7, 7, 7, 7, 7, 7, 7), 30, 1'b0, 64'd0, 1'b1);
    expect_all("t4.partial");
    send_frame(mk_frame(8'h41, 6'h3F, 1, 1, 1, 1, 1, 1, 1), 56, 1'b0, 64'd0, 1'b1);
    set_slot(1, 0, 0, 0, 0, 0, 0, 0, 0);
    men = 4'b0001;
    expect_all("t4.clear");

    // 5: extra rises beyond the frame are ignored; reset mid-frame
    send_frame(mk_frame(8'h82, 6'h3F, 127, 64, 0, 63, 32, 1, 2) | 64'h0F00_0000_0000_0000,
               60, 1'b0, 64'd0, 1'b1);
    set_slot(2, 6'h3F, 127, 64, 0, 63, 32, 1, 2);
    men = 4'b0101;
    expect_all("t5.overrun");
    send_frame(mk_frame(8'h83, 6'h15, 10, 20, 30, 40, 50, 60, 3), 20, 1'b0, 64'd0, 1'b0);
    #1 rst_n = 1'b0; cs_in = 1'b1; sck_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    model_reset();
    expect_all("t5.reset");
    send_frame(mk_frame(8'h83, 6'h15, 10, 20, 30, 40, 50, 60, 3), 56, 1'b0, 64'd0, 1'b1);
    set_slot(3, 6'h15, 10, 20, 30, 40, 50, 60, 3);
    men = 4'b1000;
    expect_all("t5.after_reset");

    @(negedge clk); #1;
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
